// File: rtl/tub_pkg.sv
// Shared types and helpers for the tub scan controller.
// Optional TUB_DIMMING_EN adds a per-window brightness slicer.
package tub_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } tub_state_e;

  localparam int unsigned MAX_W = 32;

  localparam logic [MAX_W-1:0] SEG_BLANK = '0;

  function automatic logic [MAX_W-1:0] onehot(
    input int unsigned idx,
    input int unsigned n
  );
    logic [MAX_W-1:0] r;
    r = '0;
    if (idx < n && idx < MAX_W)
      r = MAX_W'(1) << idx;
    return r;
  endfunction

  function automatic int unsigned digit_lsb(
    input int unsigned idx,
    input int unsigned seg_w
  );
    return idx * seg_w;
  endfunction

endpackage

// File: rtl/tub_scan_timer.sv
// BLANK/ON sequencer: cycle counter, digit index, frame strobes.
// TUB_DIMMING_EN exposes the counter and window-start strobe.
module tub_scan_timer
  import tub_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int IDX_W      = $clog2(NUM_DIGITS),
  parameter int CNT_W      = $clog2(
    ((SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output tub_state_e       state,
  output logic [IDX_W-1:0] idx,
`ifdef TUB_DIMMING_EN
  output logic [CNT_W-1:0] cnt,
  output logic             on_start,
`endif
  output logic             boundary,
  output logic             frame_done
);

  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST =
    CNT_W'(SCAN_DIV - 1);

  tub_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fd_q, fd_d;
  logic             blank_end, on_end, bnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    unique case (1'b1)
      !en: begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
      blank_end: begin
        state_d = ON;
        cnt_d   = '0;
      end
      on_end: begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = (idx_q == IDX_LAST) ?
                  '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    blank_end = en && state_q == BLANK &&
                cnt_q == BLANK_LAST;
    on_end    = en && state_q == ON &&
                cnt_q == ON_LAST;
    bnd       = on_end && idx_q == IDX_LAST;
    fd_d      = bnd;
  end

  assign state      = state_q;
  assign idx        = idx_q;
  assign boundary   = bnd;
  assign frame_done = fd_q;
`ifdef TUB_DIMMING_EN
  assign cnt        = cnt_q;
  assign on_start   = blank_end;
`endif

endmodule

// File: rtl/tub_scan_ctrl.sv
// Seven-segment scan controller: frame-synced data, blink, muxing.
// Define TUB_DIMMING_EN for the 16-slice brightness control.
module tub_scan_ctrl
  import tub_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SEG_W        = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
`ifdef TUB_DIMMING_EN
  input  logic [3:0]                  brightness,
`endif
  output logic [NUM_DIGITS-1:0]       tub_sel,
  output logic [SEG_W-1:0]            tub_data1,
  output logic [SEG_W-1:0]            tub_data2,
  output logic                        frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(
    ((SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC) + 1);
  localparam int FC_W  = $clog2(BLINK_FRAMES + 1);
  localparam int BUS_W = NUM_DIGITS * SEG_W;

  localparam logic [IDX_W-1:0] HALF =
    IDX_W'(NUM_DIGITS / 2);
  localparam logic [FC_W-1:0] FC_LAST =
    FC_W'(BLINK_FRAMES - 1);

  tub_state_e       state;
  logic [IDX_W-1:0] idx;
  logic             boundary;

  logic [BUS_W-1:0]      pending_q, pending_d;
  logic [BUS_W-1:0]      active_q, active_d;
  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0] tub_sel_q, tub_sel_d;
  logic [SEG_W-1:0]      data1_q, data1_d;
  logic [SEG_W-1:0]      data2_q, data2_d;
  logic [SEG_W-1:0]      digit;

`ifdef TUB_DIMMING_EN
  localparam int SLICE = SCAN_DIV / 16;

  logic [CNT_W-1:0] cnt;
  logic             on_start;
  logic [3:0]       bright_q, bright_d;
  logic [CNT_W-1:0] slice;
`endif

  tub_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk        (sys_clk),
    .rst_n      (rst_n),
    .en         (en),
    .state      (state),
    .idx        (idx),
`ifdef TUB_DIMMING_EN
    .cnt        (cnt),
    .on_start   (on_start),
`endif
    .boundary   (boundary),
    .frame_done (frame_done)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      active_q  <= '0;
      fcnt_q    <= '0;
      phase_q   <= 1'b0;
      tub_sel_q <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      fcnt_q    <= fcnt_d;
      phase_q   <= phase_d;
      tub_sel_q <= tub_sel_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
    end
  end

`ifdef TUB_DIMMING_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) bright_q <= '0;
    else        bright_q <= bright_d;
  end

  always_comb begin
    bright_d = bright_q;
    if (!en)          bright_d = '0;
    else if (on_start) bright_d = brightness;
    slice = cnt / CNT_W'(SLICE);
  end
`endif

  // A load in the boundary cycle bypasses pending so it is not a frame late.
  always_comb begin
    pending_d = load ? seg_data : pending_q;
    active_d  = active_q;
    if (boundary)
      active_d = load ? seg_data : pending_q;
  end

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!en) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (boundary) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    tub_sel_d = '0;
    data1_d   = '0;
    data2_d   = '0;
    digit     = SEG_W'(SEG_BLANK);
    if (en && state == ON) begin
      tub_sel_d = NUM_DIGITS'(onehot(32'(idx), NUM_DIGITS));
      digit = active_q[digit_lsb(32'(idx), SEG_W) +: SEG_W];
      if (phase_q && blink_mask[idx])
        digit = SEG_W'(SEG_BLANK);
`ifdef TUB_DIMMING_EN
      if (slice > CNT_W'(bright_q))
        digit = SEG_W'(SEG_BLANK);
`endif
      if (idx >= HALF) data1_d = digit;
      else             data2_d = digit;
    end
  end

  assign tub_sel   = tub_sel_q;
  assign tub_data1 = data1_q;
  assign tub_data2 = data2_q;

endmodule
